mult_wb_merge: RTL and testbench

- Stage directly downstream of the M4 multiply stage. Takes the M4 results (regwrite, destination, result, overflow) and merges them onto the single register-file write port.
- Shares that port with the main integer pipeline writeback, which always has priority.
- Multiply results that cannot write immediately wait in a small in-order FIFO, with back-pressure to the multiply pipe and a pending-destination lookup for the decode hazard check.

---
 rtl/mult_wb_merge_if.sv | 41 ++++
 rtl/mult_wb_merge.sv | 144 ++++++++++++++
 tb/tb_mult_wb_merge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_wb_merge_if.sv
// Signal bundle between the M4 multiply stage, main writeback, decode query
// and the shared register-file write port.
interface mult_wb_merge_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              mult_valid;
   logic [ADDR_W-1:0] mult_dst;
   logic [DATA_W-1:0] mult_result;
   logic              mult_overflow;
   logic              wb_regwrite;
   logic [ADDR_W-1:0] wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] q_addr;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              rf_src_mult;
   logic              mult_stall;
   logic              mult_exc;
   logic              lost_err;
   logic              pend_hit;
   logic [CW-1:0]     count;

   modport master (
      output mult_valid, mult_dst, mult_result, mult_overflow,
             wb_regwrite, wb_dst, wb_data, q_addr,
      input  rf_we, rf_waddr, rf_wdata, rf_src_mult,
             mult_stall, mult_exc, lost_err, pend_hit, count
   );

   modport slave (
      input  mult_valid, mult_dst, mult_result, mult_overflow,
             wb_regwrite, wb_dst, wb_data, q_addr,
      output rf_we, rf_waddr, rf_wdata, rf_src_mult,
             mult_stall, mult_exc, lost_err, pend_hit, count
   );
endinterface

// File: rtl/mult_wb_merge.sv
// Merges M4 multiply results onto the single register-file write port behind
// main-pipeline writeback, buffering in an in-order FIFO with kill/skip support.
module mult_wb_merge #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input logic           clk,
   input logic           reset,
   mult_wb_merge_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_C = CW'(DEPTH - 1);

   logic [DEPTH-1:0]  valid_q, valid_d;
   logic [ADDR_W-1:0] dst_q  [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              rf_src_q, rf_src_d;
   logic              exc_q, exc_d;
   logic              lost_q, lost_d;

   logic wb_act, live, arr, empty, full, push, pop, hit;

   always_comb begin
      wb_act = bus.wb_regwrite && (bus.wb_dst != '0);
      live   = bus.mult_valid && !bus.mult_overflow && (bus.mult_dst != '0);
      arr    = live && !(wb_act && (bus.mult_dst == bus.wb_dst));
      empty  = (count_q == '0);
      full   = (count_q == FULL_C);

      valid_d    = valid_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      rf_src_d   = rf_src_q;
      push       = 1'b0;
      pop        = 1'b0;

      if (wb_act) begin
         // Main write is younger: any buffered result for the same register is stale.
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (dst_q[i] == bus.wb_dst)) valid_d[i] = 1'b0;
         end
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.wb_dst;
         rf_wdata_d = bus.wb_data;
         rf_src_d   = 1'b0;
         push       = arr && !full;
      end else if (!empty) begin
         pop = 1'b1;
         if (valid_q[rd_ptr_q]) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = dst_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
            rf_src_d   = 1'b1;
         end
         push = arr;
      end else if (arr) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.mult_dst;
         rf_wdata_d = bus.mult_result;
         rf_src_d   = 1'b1;
      end

      // Pop clears before push sets so a full FIFO can recycle the head slot.
      if (pop) begin
         valid_d[rd_ptr_q] = 1'b0;
         rd_ptr_d          = rd_ptr_q + 1'b1;
      end
      if (push) begin
         valid_d[wr_ptr_q] = 1'b1;
         wr_ptr_d          = wr_ptr_q + 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;

      exc_d  = bus.mult_valid && bus.mult_overflow;
      lost_d = lost_q || (arr && full && !pop);
   end

   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (dst_q[i] == bus.q_addr)) hit = 1'b1;
      end
      if (live && (bus.mult_dst == bus.q_addr)) hit = 1'b1;
      if (bus.q_addr == '0) hit = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_src_q   <= 1'b0;
         exc_q      <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         valid_q    <= valid_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_src_q   <= rf_src_d;
         exc_q      <= exc_d;
         lost_q     <= lost_d;
      end
   end

   // Payload storage needs no reset; occupancy is tracked by valid_q.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         dst_q[wr_ptr_q]  <= bus.mult_dst;
         data_q[wr_ptr_q] <= bus.mult_result;
      end
   end

   assign bus.rf_we       = rf_we_q;
   assign bus.rf_waddr    = rf_waddr_q;
   assign bus.rf_wdata    = rf_wdata_q;
   assign bus.rf_src_mult = rf_src_q;
   assign bus.mult_exc    = exc_q;
   assign bus.lost_err    = lost_q;
   assign bus.count       = count_q;
   assign bus.mult_stall  = (count_q >= STALL_C);
   assign bus.pend_hit    = hit;
endmodule

// File: tb/tb_mult_wb_merge.sv
// Scoreboard bench for mult_wb_merge: expected port writes are queued in
// program order and matched against every rf_we pulse.
module tb_mult_wb_merge;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mult_wb_merge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

   mult_wb_merge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              src;
   } wr_t;

   wr_t exp_q[$];
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int unsigned addr, input int unsigned data, input bit src);
      wr_t e;
      e.addr = ADDR_W'(addr);
      e.data = DATA_W'(data);
      e.src  = src;
      exp_q.push_back(e);
   endtask

   task automatic set_in(input bit mv, input int unsigned mdst, input int unsigned mres,
                         input bit movf, input bit wv, input int unsigned wdst,
                         input int unsigned wdata);
      bus.mult_valid    = mv;
      bus.mult_dst      = ADDR_W'(mdst);
      bus.mult_result   = DATA_W'(mres);
      bus.mult_overflow = movf;
      bus.wb_regwrite   = wv;
      bus.wb_dst        = ADDR_W'(wdst);
      bus.wb_data       = DATA_W'(wdata);
   endtask

   task automatic idle();
      set_in(1'b0, 0, 0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (bus.rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_we", 64'(bus.rf_we), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check_eq("wr_addr", 64'(bus.rf_waddr), 64'(e.addr));
            check_eq("wr_data", 64'(bus.rf_wdata), 64'(e.data));
            check_eq("wr_src",  64'(bus.rf_src_mult), 64'(e.src));
         end
      end
   end

   initial begin
      reset      = 1'b1;
      bus.q_addr = '0;
      idle();
      repeat (3) cyc();
      check_eq("rst_we",    64'(bus.rf_we),       64'(0));
      check_eq("rst_src",   64'(bus.rf_src_mult), 64'(0));
      check_eq("rst_count", 64'(bus.count),       64'(0));
      check_eq("rst_lost",  64'(bus.lost_err),    64'(0));
      check_eq("rst_exc",   64'(bus.mult_exc),    64'(0));
      check_eq("rst_stall", 64'(bus.mult_stall),  64'(0));
      reset = 1'b0;

      // Bypass with empty FIFO; pend_hit from the arrival itself
      set_in(1'b1, 7, 32'h1234, 1'b0, 1'b0, 0, 0);
      bus.q_addr = 5'd7;
      #1;
      check_eq("pend_arrival", 64'(bus.pend_hit), 64'(1));
      push_exp(7, 32'h1234, 1'b1);
      cyc();
      idle();
      bus.q_addr = '0;
      check_eq("bypass_count", 64'(bus.count), 64'(0));
      cyc();

      // Main writeback priority, stall threshold, in-order drain
      for (int i = 0; i < 4; i++) push_exp(3, 32'hAAAA, 1'b0);
      push_exp(8, 32'h88, 1'b1);
      push_exp(9, 32'h99, 1'b1);
      push_exp(10, 32'hA0, 1'b1);
      set_in(1'b1, 8, 32'h88, 1'b0, 1'b1, 3, 32'hAAAA);
      cyc();
      set_in(1'b1, 9, 32'h99, 1'b0, 1'b1, 3, 32'hAAAA);
      cyc();
      check_eq("stall_at2", 64'(bus.mult_stall), 64'(0));
      set_in(1'b1, 10, 32'hA0, 1'b0, 1'b1, 3, 32'hAAAA);
      cyc();
      check_eq("count_at3", 64'(bus.count), 64'(3));
      check_eq("stall_at3", 64'(bus.mult_stall), 64'(1));
      set_in(1'b0, 0, 0, 1'b0, 1'b1, 3, 32'hAAAA);
      cyc();
      idle();
      repeat (3) cyc();
      check_eq("drain_count", 64'(bus.count), 64'(0));
      check_eq("drain_stall", 64'(bus.mult_stall), 64'(0));

      // Kill of a buffered entry, skipped head slot
      push_exp(1, 32'h11, 1'b0);
      push_exp(2, 32'h22, 1'b0);
      push_exp(5, 32'h5555, 1'b0);
      push_exp(6, 32'h66, 1'b1);
      set_in(1'b1, 5, 32'h55, 1'b0, 1'b1, 1, 32'h11);
      cyc();
      set_in(1'b1, 6, 32'h66, 1'b0, 1'b1, 2, 32'h22);
      cyc();
      idle();
      bus.q_addr = 5'd5;
      #1;
      check_eq("pend_q5_before", 64'(bus.pend_hit), 64'(1));
      set_in(1'b0, 0, 0, 1'b0, 1'b1, 5, 32'h5555);
      cyc();
      idle();
      #1;
      check_eq("pend_q5_after", 64'(bus.pend_hit), 64'(0));
      check_eq("kill_count", 64'(bus.count), 64'(2));
      bus.q_addr = '0;
      cyc();
      check_eq("skip_we", 64'(bus.rf_we), 64'(0));
      check_eq("skip_count", 64'(bus.count), 64'(1));
      cyc();
      check_eq("kill_drained", 64'(bus.count), 64'(0));

      // Overflow discard pulses mult_exc once; dst 0 dropped silently
      set_in(1'b1, 4, 32'h44, 1'b1, 1'b0, 0, 0);
      cyc();
      check_eq("exc_pulse", 64'(bus.mult_exc), 64'(1));
      idle();
      cyc();
      check_eq("exc_clear", 64'(bus.mult_exc), 64'(0));
      set_in(1'b1, 0, 32'h99, 1'b0, 1'b0, 0, 0);
      cyc();
      idle();
      check_eq("dst0_exc", 64'(bus.mult_exc), 64'(0));
      check_eq("dst0_count", 64'(bus.count), 64'(0));
      cyc();

      // Overfill: fifth arrival while full is lost
      for (int i = 0; i < 5; i++) push_exp(3, 32'h100 + i, 1'b0);
      for (int i = 0; i < 4; i++) push_exp(11 + i, 32'hB0 + i, 1'b1);
      for (int i = 0; i < 4; i++) begin
         set_in(1'b1, 11 + i, 32'hB0 + i, 1'b0, 1'b1, 3, 32'h100 + i);
         cyc();
      end
      check_eq("full_count", 64'(bus.count), 64'(4));
      check_eq("full_lost0", 64'(bus.lost_err), 64'(0));
      set_in(1'b1, 15, 32'hF5, 1'b0, 1'b1, 3, 32'h104);
      cyc();
      check_eq("lost_set", 64'(bus.lost_err), 64'(1));
      check_eq("lost_count", 64'(bus.count), 64'(4));
      idle();
      repeat (4) cyc();
      check_eq("lost_drained", 64'(bus.count), 64'(0));
      check_eq("lost_sticky", 64'(bus.lost_err), 64'(1));

      // wb_regwrite to register 0 is not a main write; arrival bypasses
      push_exp(20, 32'h2020, 1'b1);
      set_in(1'b1, 20, 32'h2020, 1'b0, 1'b1, 0, 32'hDEAD);
      cyc();
      idle();
      cyc();

      // Reset with pending entries discards them
      for (int i = 0; i < 3; i++) push_exp(3, 32'h300 + i, 1'b0);
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 21 + i, 32'hC0 + i, 1'b0, 1'b1, 3, 32'h300 + i);
         cyc();
      end
      check_eq("prerst_count", 64'(bus.count), 64'(3));
      idle();
      reset = 1'b1;
      cyc();
      check_eq("midrst_count", 64'(bus.count), 64'(0));
      check_eq("midrst_we", 64'(bus.rf_we), 64'(0));
      check_eq("midrst_lost", 64'(bus.lost_err), 64'(0));
      reset = 1'b0;
      repeat (6) cyc();
      check_eq("postrst_count", 64'(bus.count), 64'(0));
      check_eq("sb_drained", 64'(exp_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
